// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the sizing helper for the wait timer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_START,
    WAIT_DONE,
    WAIT_NEXT
  } state_t;

  // Width needed to hold values 0..max_count inclusive.
  function automatic int timer_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// ptr+1, wrapping modulo N. Returns the winner one-hot and as an index.
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] winner_idx,
  output logic          found
);

  logic [IW-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional code, otherwise an unassigned path infers a latch.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        winner[cand] = 1'b1;
        winner_idx  = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte-stream requesters with
// round-robin arbitration, packet locking and per-wait timeouts.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CLKS = 65535,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_byte,
  output logic                 send_byte,
  input  logic                 sending_byte,
  output logic                 err_timeout,
  output logic                 busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = timer_width(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CLKS);

  state_t               state, state_d;
  logic [NUM_REQ-1:0]   grant_d, req_ready_d, pick_onehot;
  logic [IW-1:0]        owner, owner_d, rr_ptr, rr_ptr_d, pick_idx;
  logic                 pick_found, last_q, last_d, send_byte_d, err_d;
  logic [7:0]           tx_byte_d;
  logic [TW-1:0]        timer;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 sb_s, in_wait;

  // The transmitter runs on a divided clock; only the synchronized copy is used.
  assign sb_s    = sync_q[SYNC_STAGES-1];
  assign busy    = (state != IDLE);
  assign in_wait = (state == WAIT_START) || (state == WAIT_DONE) || (state == WAIT_NEXT);

  uart_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .found      (pick_found)
  );

  always_comb begin
    state_d     = state;
    grant_d     = grant;
    owner_d     = owner;
    rr_ptr_d    = rr_ptr;
    last_d      = last_q;
    tx_byte_d   = tx_byte;
    send_byte_d = send_byte;
    req_ready_d = '0;
    err_d       = 1'b0;
    if (in_wait && timer == TIMER_MAX) begin
      // Abort keeps the owner in rr_ptr so it goes to the back of the queue.
      err_d       = 1'b1;
      send_byte_d = 1'b0;
      grant_d     = '0;
      rr_ptr_d    = owner;
      state_d     = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_d = pick_onehot;
            owner_d = pick_idx;
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (req_valid[owner]) begin
            tx_byte_d          = req_data[{owner, 3'b000} +: 8];
            last_d             = req_last[owner];
            req_ready_d[owner] = 1'b1;
            send_byte_d        = 1'b1;
            state_d            = WAIT_START;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
        WAIT_START: begin
          // A stale high sb_s is taken as the start acknowledge.
          if (sb_s) begin
            send_byte_d = 1'b0;
            state_d     = WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!sb_s) begin
            if (last_q) begin
              grant_d  = '0;
              rr_ptr_d = owner;
              state_d  = IDLE;
            end else begin
              state_d = WAIT_NEXT;
            end
          end
        end
        WAIT_NEXT: begin
          if (req_valid[owner]) state_d = LOAD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= '0;
      rr_ptr      <= IW'(NUM_REQ - 1);
      last_q      <= 1'b0;
      tx_byte     <= '0;
      send_byte   <= 1'b0;
      req_ready   <= '0;
      err_timeout <= 1'b0;
      timer       <= '0;
      sync_q      <= '0;
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      owner       <= owner_d;
      rr_ptr      <= rr_ptr_d;
      last_q      <= last_d;
      tx_byte     <= tx_byte_d;
      send_byte   <= send_byte_d;
      req_ready   <= req_ready_d;
      err_timeout <= err_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], sending_byte};
      if (state_d != state) timer <= '0;
      else if (timer != TIMER_MAX) timer <= timer + 1'b1;
    end
  end

endmodule
